// File: rtl/zebu_clk_event_sched_if.sv
// zebu_clk_event_sched_if: requester, handshake and status signals of the clock event scheduler
interface zebu_clk_event_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
);
   localparam int ID_W = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0] req_pulse;
   logic [NUM_REQ-1:0] req_mask;
   logic               stop_req;
   logic               stop_ack;
   logic               grant_vld;
   logic [ID_W-1:0]    grant_id;
   logic [NUM_REQ-1:0] pend;
   logic [CNT_W-1:0]   evt_cnt;
   logic               ovf;
   logic               timeout;
   modport master (
      output req_pulse, req_mask, stop_ack,
      input  stop_req, grant_vld, grant_id, pend, evt_cnt, ovf, timeout
   );
   modport slave (
      input  req_pulse, req_mask, stop_ack,
      output stop_req, grant_vld, grant_id, pend, evt_cnt, ovf, timeout
   );
endinterface

// File: rtl/zebu_clk_event_sched.sv
// zebu_clk_event_sched: round-robin arbiter turning clock-detect pulses into a 4-phase stop_req/stop_ack handshake
// Define ZEBU_CLK_EVENT_SCHED_TIMEOUT_EN to enable the stop-ack watchdog; otherwise timeout is tied 0.
module zebu_clk_event_sched #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16,
   parameter int TMO_CYC = 1024
) (
   input logic clk,
   input logic rst,
   zebu_clk_event_sched_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, STOP, REL} state_t;
   state_t st_q, st_d;
   logic [NUM_REQ-1:0] pend_q, pend_d, elig, clr;
   logic [ID_W-1:0] gid_q, ptr_q, sel;
   logic [CNT_W-1:0] cnt_q;
   logic ovf_q, tmo_q, found, take, tmo_hit;
   int j;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TMO_CYC < 1) begin : g_bad_param
      $error("zebu_clk_event_sched: parameter out of range");
   end

   // Scan downward so the first eligible index at or after ptr_q wins.
   always_comb begin
      elig = pend_q & ~bus.req_mask;
      sel = '0;
      found = 1'b0;
      j = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr_q) + k;
         j = (j >= NUM_REQ) ? j - NUM_REQ : j;
         if (elig[j]) begin
            sel = ID_W'(j);
            found = 1'b1;
         end
      end
   end

`ifdef ZEBU_CLK_EVENT_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tc_q;
   always_ff @(posedge clk)
      tc_q <= (rst || st_q != STOP) ? '0 : tc_q + 1'b1;
   assign tmo_hit = st_q == STOP && !bus.stop_ack && tc_q == TW'(TMO_CYC - 1);
`else
   assign tmo_hit = 1'b0;
`endif

   // Granting waits for stop_ack low, so an ack left high across reset is ignored.
   always_comb begin
      st_d = st_q;
      take = 1'b0;
      case (st_q)
         IDLE: begin
            take = found && !bus.stop_ack;
            st_d = take ? STOP : IDLE;
         end
         STOP:    st_d = (bus.stop_ack || tmo_hit) ? REL : STOP;
         REL:     st_d = bus.stop_ack ? REL : IDLE;
         default: st_d = IDLE;
      endcase
      clr = take ? NUM_REQ'(1) << sel : '0;
      pend_d = (pend_q & ~clr) | bus.req_pulse;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= IDLE;
         pend_q <= '0;
         gid_q  <= '0;
         ptr_q  <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         tmo_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_q | (|(bus.req_pulse & pend_q & ~clr));
         tmo_q  <= tmo_q | tmo_hit;
         if (take) begin
            gid_q <= sel;
            ptr_q <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
         end
      end
   end

   assign bus.stop_req  = st_q == STOP;
   assign bus.grant_vld = st_q == STOP;
   assign bus.grant_id  = gid_q;
   assign bus.pend      = pend_q;
   assign bus.evt_cnt   = cnt_q;
   assign bus.ovf       = ovf_q;
   assign bus.timeout   = tmo_q;
endmodule
